// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_pkg
//  Description : Shared ECC definitions: curve-check FSM encoding, latency
//                constants and NIST P-192 domain parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package ecc_pkg;

    // Sequencing states of the point-on-curve checker
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        MUL_YY = 4'd2,
        MUL_XX = 4'd3,
        ADD_A  = 4'd4,
        MUL_X  = 4'd5,
        ADD_B  = 4'd6,
        CMP    = 4'd7,
        FIN    = 4'd8
    } state_e;

    // Latency helpers for an arbitrary operand width
    function automatic int mul_cycles(input int n);
        return n + 1;
    endfunction

    function automatic int check_latency(input int n);
        return 3 * n + 8;
    endfunction

    // Latency constants for the default 192-bit configuration
    localparam int P192_N        = 192;
    localparam int MUL_CYCLES    = P192_N + 1;
    localparam int CHECK_LATENCY = 3 * P192_N + 8;

    // NIST P-192 domain parameters
    localparam logic [191:0] P192_P  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    localparam logic [191:0] P192_A  = 192'hfffffffffffffffffffffffffffffffefffffffffffffffc;
    localparam logic [191:0] P192_B  = 192'h64210519e59c80e70fa7e9ab72243049feb8deecc146b9b1;
    localparam logic [191:0] P192_GX = 192'h188da80eb03090f67cbf20eb43a18800f4ff0afd82ff1012;
    localparam logic [191:0] P192_GY = 192'h07192b95ffc8da78631011ed6b24cdd573f977a11e794811;

endpackage
`default_nettype wire

// File: rtl/mod_mult_serial.sv
`default_nettype none
// ============================================================================
//  Module      : mod_mult_serial
//  Description : Bit-serial interleaved modular multiplier, r = op_a*op_b mod p.
//                Operands latched on the start edge, N MSB-first iterations
//                follow; done rises with the final iteration and holds.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_mult_serial #(
    parameter int N = 192
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         done,
    output logic [N-1:0] r
);
    import ecc_pkg::*;

    localparam int               CNT_W   = $clog2(N + 1);
    localparam logic [CNT_W-1:0] C_ITERS = CNT_W'(N);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    // Accumulator is two bits wider than p: 2r + a stays below 3p
    logic [N+1:0]     acc_q, acc_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [N+1:0]     w_p_ext, w_dbl, w_sub1, w_sub2;

    // One iteration: double, add multiplicand on a set bit, reduce twice
    always_comb begin
        w_p_ext  = {2'b00, p};
        w_dbl    = (acc_q << 1) + (mplier_q[N-1] ? {2'b00, mcand_q} : '0);
        w_sub1   = (w_dbl  >= w_p_ext) ? (w_dbl  - w_p_ext) : w_dbl;
        w_sub2   = (w_sub1 >= w_p_ext) ? (w_sub1 - w_p_ext) : w_sub1;

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = done_q;

        if (start) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = C_ITERS;
            done_d   = 1'b0;
        end else if (cnt_q != '0) begin
            acc_d    = w_sub2;
            mplier_d = mplier_q << 1;
            cnt_d    = cnt_q - C_ONE;
            if (cnt_q == C_ONE) begin
                done_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign r    = acc_q[N-1:0];

endmodule
`default_nettype wire

// File: rtl/point_on_curve_check.sv
`default_nettype none
// ============================================================================
//  Module      : point_on_curve_check
//  Description : Checks y^2 == x^3 + a*x + b (mod p) for an affine point, with
//                fast paths for infinity and out-of-range coordinates. One
//                shared serial multiplier is time-shared by the MUL states.
//  Revision    : 1.0  initial release
// ============================================================================
module point_on_curve_check #(
    parameter int N = 192
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         inf,
    output logic         busy,
    output logic         done,
    output logic         on_curve
);
    import ecc_pkg::*;

    state_e       state_q, state_d;
    logic [N-1:0] p_q, p_d, a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
    logic         inf_q, inf_d;
    logic [N-1:0] t_q, t_d, yy_q, yy_d;
    logic         busy_q, busy_d, done_q, done_d, on_q, on_d;

    logic         w_accept;
    logic         w_mul_start, w_mul_done;
    logic [N-1:0] w_mul_a, w_mul_b, w_mul_r;

    // (u + v) mod m for u, v < m using an (N+1)-bit sum
    function automatic logic [N-1:0] mod_add(input logic [N-1:0] u, v, m);
        logic [N:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[N-1:0];
    endfunction

    // FIN already shows done, so a start there is accepted like in IDLE
    assign w_accept = start && ((state_q == IDLE) || (state_q == FIN));

    mod_mult_serial #(.N(N)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .p     (p_q),
        .op_a  (w_mul_a),
        .op_b  (w_mul_b),
        .done  (w_mul_done),
        .r     (w_mul_r)
    );

    // Next-state, datapath updates and multiplier issue
    always_comb begin
        state_d     = state_q;
        p_d = p_q; a_d = a_q; b_d = b_q; x_d = x_q; y_d = y_q; inf_d = inf_q;
        t_d         = t_q;
        yy_d        = yy_q;
        busy_d      = busy_q;
        done_d      = done_q;
        on_d        = on_q;
        w_mul_start = 1'b0;
        w_mul_a     = y_q;
        w_mul_b     = y_q;

        if (w_accept) begin
            p_d = p; a_d = a; b_d = b; x_d = x; y_d = y; inf_d = inf;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            on_d    = 1'b0;
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    if (inf_q || (x_q >= p_q) || (y_q >= p_q)) begin
                        on_d    = inf_q;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        w_mul_start = 1'b1;
                        state_d     = MUL_YY;
                    end
                end
                // Result is read straight off the multiplier as it completes
                MUL_YY: begin
                    if (w_mul_done) begin
                        yy_d        = w_mul_r;
                        w_mul_start = 1'b1;
                        w_mul_a     = x_q;
                        w_mul_b     = x_q;
                        state_d     = MUL_XX;
                    end
                end
                MUL_XX: begin
                    if (w_mul_done) begin
                        t_d     = w_mul_r;
                        state_d = ADD_A;
                    end
                end
                ADD_A: begin
                    t_d         = mod_add(t_q, a_q, p_q);
                    w_mul_start = 1'b1;
                    w_mul_a     = t_d;
                    w_mul_b     = x_q;
                    state_d     = MUL_X;
                end
                MUL_X: begin
                    if (w_mul_done) begin
                        t_d     = w_mul_r;
                        state_d = ADD_B;
                    end
                end
                ADD_B: begin
                    t_d     = mod_add(t_q, b_q, p_q);
                    state_d = CMP;
                end
                CMP: begin
                    on_d    = (t_q == yy_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q <= '0; a_q <= '0; b_q <= '0; x_q <= '0; y_q <= '0;
            inf_q   <= 1'b0;
            t_q     <= '0;
            yy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d; a_q <= a_d; b_q <= b_d; x_q <= x_d; y_q <= y_d;
            inf_q   <= inf_d;
            t_q     <= t_d;
            yy_q    <= yy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            on_q    <= on_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign on_curve = on_q;

endmodule
`default_nettype wire
